// File: rtl/car_alarm_pkg.sv
// Shared constants for the car alarm switch front end: channel indices and default sizing.
package car_alarm_pkg;

  localparam int SW_DRIVER_DOOR    = 0;
  localparam int SW_PASSENGER_DOOR = 1;
  localparam int SW_IGNITION       = 2;
  localparam int SW_HIDDEN         = 3;
  localparam int SW_BRAKE          = 4;

  localparam int N_SW_DEFAULT        = 5;
  localparam int DEBOUNCE_10MS_50MHZ = 500000;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-FF synchroniser, stability counter and, with SW_EDGE_PULSE_EN,
// registered rise/fall pulses aligned with the first cycle of the new stable level.
module sw_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw_i,
`ifdef SW_EDGE_PULSE_EN
  output logic sw_rise_o,
  output logic sw_fall_o,
`endif
  output logic sw_stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where the synchronised level matches the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= sw_raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sw_stable_o = stable_q;

`ifdef SW_EDGE_PULSE_EN
  logic rise_q;
  logic fall_q;

  // Pulses are registered from the same next-state so they coincide with the level change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= stable_d & ~stable_q;
      fall_q <= ~stable_d & stable_q;
    end
  end

  assign sw_rise_o = rise_q;
  assign sw_fall_o = fall_q;
`endif

endmodule

// File: rtl/switch_input_conditioner.sv
// Synchronises and debounces the raw alarm switch pins, one independent channel per pin.
// Optional SW_EDGE_PULSE_EN adds one-cycle sw_rise/sw_fall outputs.
module switch_input_conditioner
  import car_alarm_pkg::*;
#(
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
`ifdef SW_EDGE_PULSE_EN
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
`endif
  output logic [N_SW-1:0] sw_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .sw_raw_i   (sw_raw[g]),
`ifdef SW_EDGE_PULSE_EN
      .sw_rise_o  (sw_rise[g]),
      .sw_fall_o  (sw_fall[g]),
`endif
      .sw_stable_o(sw_stable[g])
    );
  end

endmodule
